// File: rtl/rgb_palette_lut.sv
// Programmable colour-palette lookup: a writable palette feeds a two-stage pipeline
// that registers the looked-up entry, then applies per-channel brightness scaling.
module rgb_palette_lut #(
    parameter int IDX_W = 3,
    parameter int CH_W  = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enable,
    input  logic [IDX_W-1:0]    colour,
    input  logic [CH_W-1:0]     bright,
    input  logic                wr_en,
    input  logic [IDX_W-1:0]    wr_addr,
    input  logic [3*CH_W-1:0]   wr_data,
    output logic [3*CH_W-1:0]   rgb,
    output logic                rgb_valid
);

    localparam int DEPTH  = 1 << IDX_W;
    localparam int RGB_W  = 3 * CH_W;
    localparam int PROD_W = 2 * CH_W + 1;

    // Default pattern repeats every 8 entries: index bits 2/1/0 select R/G/B full scale.
    function automatic logic [RGB_W-1:0] default_entry(input logic [2:0] idx);
        return {{CH_W{idx[2]}}, {CH_W{idx[1]}}, {CH_W{idx[0]}}};
    endfunction

    // c * (b + 1) never exceeds 2*CH_W bits, so the shifted result always fits CH_W.
    function automatic logic [CH_W-1:0] scale_ch(input logic [CH_W-1:0] ch,
                                                 input logic [CH_W-1:0] br);
        logic [PROD_W-1:0] w_prod;
        w_prod = PROD_W'(ch) * PROD_W'({1'b0, br} + (CH_W+1)'(1));
        return CH_W'(w_prod >> CH_W);
    endfunction

    logic [RGB_W-1:0] r_palette [DEPTH];
    logic [RGB_W-1:0] r_s1_data;
    logic [CH_W-1:0]  r_s1_bright;
    logic             r_s1_valid;
    logic [RGB_W-1:0] r_rgb;
    logic             r_rgb_valid;
    logic [RGB_W-1:0] w_lookup;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_palette[i] <= default_entry(3'(i));
            end
        end else if (wr_en) begin
            r_palette[wr_addr] <= wr_data;
        end
    end

    // Write-first: a lookup of the entry being written this cycle sees the new data.
    assign w_lookup = (wr_en && (wr_addr == colour)) ? wr_data : r_palette[colour];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_data   <= '0;
            r_s1_bright <= '0;
            r_s1_valid  <= 1'b0;
        end else begin
            r_s1_valid <= enable;
            if (enable) begin
                r_s1_data   <= w_lookup;
                r_s1_bright <= bright;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rgb       <= '0;
            r_rgb_valid <= 1'b0;
        end else begin
            r_rgb_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_rgb <= {scale_ch(r_s1_data[3*CH_W-1:2*CH_W], r_s1_bright),
                          scale_ch(r_s1_data[2*CH_W-1:CH_W],   r_s1_bright),
                          scale_ch(r_s1_data[CH_W-1:0],        r_s1_bright)};
            end
        end
    end

    assign rgb       = r_rgb;
    assign rgb_valid = r_rgb_valid;

endmodule

// File: tb/tb_rgb_palette_lut.sv
// Directed bench for rgb_palette_lut: a palette/latency model checked every cycle,
// plus hand-computed literal expectations for each scenario.
module tb_rgb_palette_lut;

    localparam int IDX_W = 3;
    localparam int CH_W  = 8;
    localparam int W     = 3 * CH_W;

    logic             clk;
    logic             rst_n;
    logic             enable;
    logic [IDX_W-1:0] colour;
    logic [CH_W-1:0]  bright;
    logic             wr_en;
    logic [IDX_W-1:0] wr_addr;
    logic [W-1:0]     wr_data;
    logic [W-1:0]     rgb;
    logic             rgb_valid;

    int n_tests = 0;
    int n_fail  = 0;

    rgb_palette_lut #(.IDX_W(IDX_W), .CH_W(CH_W)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .colour(colour), .bright(bright),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rgb(rgb), .rgb_valid(rgb_valid)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // model state
    logic [W-1:0] mpal [8];
    logic [W-1:0] exp_q [$];
    int           due_q [$];
    logic [W-1:0] last_rgb;
    int           edge_cnt = 0;

    function automatic logic [W-1:0] scale(input logic [W-1:0] e, input logic [CH_W-1:0] b);
        int r, g, bl;
        r  = (int'(e[23:16]) * (int'(b) + 1)) / 256;
        g  = (int'(e[15:8])  * (int'(b) + 1)) / 256;
        bl = (int'(e[7:0])   * (int'(b) + 1)) / 256;
        return {r[7:0], g[7:0], bl[7:0]};
    endfunction

    task automatic model_reset();
        exp_q.delete();
        due_q.delete();
        last_rgb = '0;
        for (int i = 0; i < 8; i++) begin
            mpal[i] = {{8{i[2]}}, {8{i[1]}}, {8{i[0]}}};
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // model: a lookup at edge k is due at edge k+1, reading the palette before this edge's write
    always @(posedge clk) begin
        edge_cnt++;
        if (rst_n) begin
            if (enable) begin
                exp_q.push_back(scale((wr_en && wr_addr == colour) ? wr_data : mpal[colour], bright));
                due_q.push_back(edge_cnt + 1);
            end
            if (wr_en) mpal[wr_addr] = wr_data;
        end
    end

    // scoreboard compare on every falling edge
    always @(negedge clk) begin
        logic exp_v;
        exp_v = (due_q.size() > 0) && (due_q[0] == edge_cnt);
        if (exp_v) begin
            void'(due_q.pop_front());
            last_rgb = exp_q.pop_front();
        end
        check("cyc_valid", 32'(rgb_valid), 32'(exp_v));
        check("cyc_rgb", 32'(rgb), 32'(last_rgb));
    end

    // driver
    task automatic d(input logic en, input logic [IDX_W-1:0] col, input logic [CH_W-1:0] br,
                     input logic we, input logic [IDX_W-1:0] wa, input logic [W-1:0] wd);
        @(negedge clk);
        enable = en; colour = col; bright = br;
        wr_en = we; wr_addr = wa; wr_data = wd;
    endtask

    task automatic idle();
        d(1'b0, '0, '0, 1'b0, '0, '0);
    endtask

    task automatic pin(input string name, input logic [W-1:0] exp_rgb, input logic exp_v);
        check({name, "_rgb"}, 32'(rgb), 32'(exp_rgb));
        check({name, "_valid"}, 32'(rgb_valid), 32'(exp_v));
    endtask

    logic [W-1:0] def_tab [8];

    initial begin
        def_tab = '{24'h000000, 24'h0000FF, 24'h00FF00, 24'h00FFFF,
                    24'hFF0000, 24'hFF00FF, 24'hFFFF00, 24'hFFFFFF};
        enable = 0; colour = 0; bright = 0; wr_en = 0; wr_addr = 0; wr_data = 0;
        rst_n = 1'b1;
        model_reset();
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        pin("reset", 24'h000000, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // default palette streamed back-to-back
        for (int i = 0; i < 11; i++) begin
            if (i < 8) d(1'b1, 3'(i), 8'hFF, 1'b0, '0, '0);
            else       idle();
            if (i >= 2 && i < 10) pin("default", def_tab[i-2], 1'b1);
        end
        pin("stream_end", 24'hFFFFFF, 1'b0);

        // palette write, then lookups of written and neighbouring entries
        d(1'b0, 3'd0, 8'h00, 1'b1, 3'd5, 24'h123456);
        d(1'b1, 3'd5, 8'hFF, 1'b0, '0, '0);
        d(1'b1, 3'd4, 8'hFF, 1'b0, '0, '0);
        idle(); pin("write5", 24'h123456, 1'b1);
        idle(); pin("entry4", 24'hFF0000, 1'b1);

        // read/write collision is write-first
        d(1'b1, 3'd3, 8'hFF, 1'b1, 3'd3, 24'hABCDEF);
        idle();
        idle(); pin("collide", 24'hABCDEF, 1'b1);

        // brightness scaling
        d(1'b1, 3'd7, 8'h7F, 1'b0, '0, '0);
        d(1'b1, 3'd7, 8'h00, 1'b0, '0, '0);
        d(1'b0, 3'd0, 8'h00, 1'b1, 3'd6, 24'h804020); pin("bright7F", 24'h7F7F7F, 1'b1);
        d(1'b1, 3'd6, 8'h7F, 1'b0, '0, '0);           pin("bright00", 24'h000000, 1'b1);
        idle();
        idle(); pin("bright_e6", 24'h402010, 1'b1);

        // single pulse then hold
        d(1'b1, 3'd1, 8'hFF, 1'b0, '0, '0);
        idle();
        idle(); pin("pulse", 24'h0000FF, 1'b1);
        idle(); pin("hold1", 24'h0000FF, 1'b0);
        idle(); pin("hold2", 24'h0000FF, 1'b0);

        // async reset in the middle of a stream
        d(1'b0, 3'd0, 8'h00, 1'b1, 3'd2, 24'h111111);
        d(1'b1, 3'd2, 8'hFF, 1'b0, '0, '0);
        d(1'b1, 3'd2, 8'hFF, 1'b0, '0, '0);
        d(1'b1, 3'd3, 8'hFF, 1'b0, '0, '0);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        enable = 0; wr_en = 0;
        model_reset();
        #1 pin("async_rst", 24'h000000, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        idle();
        idle(); pin("no_stray", 24'h000000, 1'b0);
        d(1'b1, 3'd2, 8'hFF, 1'b0, '0, '0);
        idle();
        idle(); pin("post_rst", 24'h00FF00, 1'b1);
        repeat (3) idle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
